// File: rtl/handshake_pkg.sv
// Shared definitions for the request/key handshake between the key producer
// and the key_responder consumer stage.
package handshake_pkg;

    // Key width; the producer drives a 4-bit modulo-16 counter.
    localparam int KEY_W = 4;

    // Responder handshake states: wait for a request, then acknowledge it.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } resp_state_e;

    // One key as carried on req_key / out_key.
    typedef logic [KEY_W-1:0] key_t;

endpackage : handshake_pkg

// File: rtl/key_responder_sync_fifo.sv
// Small synchronous FIFO with registered occupancy, empty and full flags.
// The head word is read straight from storage at the registered read pointer
// and forced to zero while the registered empty flag is set, so no input of
// this block reaches an output within the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             empty_r;
    logic             full_r;

    logic             do_push_s;
    logic             do_pop_s;
    logic [CW-1:0]    count_next_s;

    // Qualify requests: pushes into a full FIFO and pops from an empty one are dropped.
    always_comb begin
        do_push_s    = push & ~full_r;
        do_pop_s     = pop & ~empty_r;
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            2'b11:   count_next_s = count_r;
            2'b00:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags; flags are precomputed so outputs stay pure flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CW{1'b0}});
            full_r  <= (count_next_s == DEPTH_C);
        end
    end

    // Storage array; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head word gated to zero while empty so stale storage never leaks out.
    always_comb begin
        if (empty_r) begin
            head_data = {WIDTH{1'b0}};
        end else begin
            head_data = mem_r[rd_ptr_r];
        end
    end

    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;

endmodule : sync_fifo

// File: rtl/key_responder.sv
// Consumer of the request/key producer. Each accepted key is acknowledged
// with a one-cycle registered ack, checked against the expected modulo-2^KEY_W
// successor of the previous key, and buffered in a FIFO drained through a
// valid/ready port. ack depends only on state flops, so the producer's
// combinational ack -> counter path cannot close a loop through this block.
module key_responder #(
    parameter int DEPTH = 4,
    parameter int KEY_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic [KEY_W-1:0]           req_key,
    output logic                       ack,
    output logic                       out_valid,
    output logic [KEY_W-1:0]           out_key,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       seq_err
);

    import handshake_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [KEY_W-1:0] KEY_ONE = KEY_W'(1);

    resp_state_e      state_r;
    resp_state_e      state_next_s;
    logic             capture_s;
    logic             ack_r;
    logic [KEY_W-1:0] exp_key_r;
    logic             seq_err_r;

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             fifo_pop_s;
    logic [CW-1:0]    fifo_count_s;
    logic [KEY_W-1:0] fifo_head_s;

    // Handshake decode: accept in IDLE only when the FIFO has room right now.
    // The full flag reflects the current occupancy, so a pop in the same
    // cycle cannot open a slot for this request.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req && !fifo_full_s) begin
                    capture_s    = 1'b1;
                    state_next_s = ACK;
                end else begin
                    capture_s    = 1'b0;
                    state_next_s = IDLE;
                end
            end
            ACK: begin
                // Producer key is stale here; it advances at the end of this cycle.
                capture_s    = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                capture_s    = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and ack flop; ack is high exactly for the ACK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ack_r   <= (state_next_s == ACK);
        end
    end

    // Order check: every captured key must equal the successor of the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_key_r <= {KEY_W{1'b0}};
            seq_err_r <= 1'b0;
        end else if (capture_s) begin
            if (req_key != exp_key_r) begin
                seq_err_r <= 1'b1;
            end
            exp_key_r <= req_key + KEY_ONE;
        end
    end

    // Consumer pop; the FIFO itself ignores pops while empty.
    always_comb begin
        fifo_pop_s = out_valid & out_ready;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture_s),
        .push_data (req_key),
        .pop       (fifo_pop_s),
        .head_data (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign ack       = ack_r;
    assign seq_err   = seq_err_r;
    assign out_valid = ~fifo_empty_s;
    assign out_key   = fifo_head_s;
    assign count     = fifo_count_s;

endmodule : key_responder

// File: tb/tb_key_responder.sv
// Self-checking bench for key_responder: directed scenarios plus a randomized
// phase, all compared against a queue-based behavioural model.
module tb_key_responder;

    import handshake_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       req;
    key_t       req_key;
    logic       ack;
    logic       out_valid;
    key_t       out_key;
    logic       out_ready;
    logic [2:0] count;
    logic       seq_err;

    int checks;
    int failures;

    // Behavioural model state
    key_t m_q[$];
    bit   m_ack;
    bit   m_err;
    key_t m_exp;

    key_t prod_key;

    key_responder #(.DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_key   (req_key),
        .ack       (ack),
        .out_valid (out_valid),
        .out_key   (out_key),
        .out_ready (out_ready),
        .count     (count),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge: a key is accepted when not acknowledging, a
    // request is present and the buffer holds fewer than DEPTH keys before the edge.
    function automatic void model_step(bit r, key_t k, bit rdy, bit rs);
        bit acc;
        bit pop;
        if (rs) begin
            m_q.delete();
            m_ack = 1'b0;
            m_err = 1'b0;
            m_exp = '0;
        end else begin
            acc = !m_ack && r && (m_q.size() < DEPTH);
            pop = rdy && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                if (k != m_exp) m_err = 1'b1;
                m_exp = key_t'((int'(k) + 1) % 16);
                m_q.push_back(k);
            end
            m_ack = acc;
        end
    endfunction

    task automatic check_all(input string tag);
        key_t head;
        head = (m_q.size() > 0) ? m_q[0] : key_t'(0);
        chk({tag, ".ack"},       32'(ack),       32'(m_ack));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
        chk({tag, ".out_key"},   32'(out_key),   32'(head));
        chk({tag, ".count"},     32'(count),     32'(m_q.size()));
        chk({tag, ".seq_err"},   32'(seq_err),   32'(m_err));
    endtask

    task automatic tick(input string tag, input bit r, input key_t k, input bit rdy, input bit rs);
        req       = r;
        req_key   = k;
        out_ready = rdy;
        rst       = rs;
        @(posedge clk);
        model_step(r, k, rdy, rs);
        #1;
        check_all(tag);
    endtask

    // Producer cycle: key advances at the end of each acknowledged cycle.
    task automatic prod_tick(input string tag, input bit rdy);
        bit a;
        a = m_ack;
        tick(tag, 1'b1, prod_key, rdy, 1'b0);
        if (a) prod_key = prod_key + 4'd1;
    endtask

    task automatic do_reset();
        tick("reset", 1'b0, 4'd0, 1'b0, 1'b1);
        tick("reset", 1'b0, 4'd0, 1'b0, 1'b1);
        prod_key = 4'd0;
    endtask

    initial begin
        int n_ack;
        int widx;
        key_t seen[$];
        checks   = 0;
        failures = 0;
        req = 1'b0; req_key = 4'd0; out_ready = 1'b0; rst = 1'b1;
        m_ack = 1'b0; m_err = 1'b0; m_exp = '0; prod_key = 4'd0;

        // Reset values
        do_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_key", 32'(out_key), 32'd0);

        // Streaming with the consumer always ready, across the 15 -> 0 wrap
        for (int c = 1; c <= 34; c++) begin
            prod_tick("stream", 1'b1);
            chk("stream_ack_parity", 32'(ack), 32'(c % 2));
            if (ack === 1'b1) seen.push_back(out_key);
        end
        chk("stream_n_keys", 32'(seen.size()), 32'd17);
        widx = 0;
        foreach (seen[i]) begin
            chk("stream_key_seq", 32'(seen[i]), 32'(i % 16));
        end
        chk("stream_seq_err", 32'(seq_err), 32'd0);

        // Consumer stalled: exactly DEPTH acks, then hold
        do_reset();
        n_ack = 0;
        for (int c = 0; c < 14; c++) begin
            prod_tick("stall", 1'b0);
            if (ack === 1'b1) n_ack++;
        end
        chk("stall_n_ack", 32'(n_ack), 32'd4);
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_ack", 32'(ack), 32'd0);
        chk("stall_head", 32'(out_key), 32'd0);
        prod_tick("stall_pop", 1'b1);
        chk("stall_pop_count", 32'(count), 32'd3);
        chk("stall_pop_ack", 32'(ack), 32'd0);
        prod_tick("stall_resume", 1'b0);
        chk("stall_resume_ack", 32'(ack), 32'd1);
        chk("stall_resume_count", 32'(count), 32'd4);

        // Out-of-order key sequence 0,1,3
        do_reset();
        tick("seq", 1'b1, 4'd0, 1'b1, 1'b0);
        tick("seq", 1'b1, 4'd0, 1'b1, 1'b0);
        tick("seq", 1'b1, 4'd1, 1'b1, 1'b0);
        tick("seq", 1'b1, 4'd1, 1'b1, 1'b0);
        chk("seq_err_before", 32'(seq_err), 32'd0);
        tick("seq", 1'b1, 4'd3, 1'b1, 1'b0);
        chk("seq_err_set", 32'(seq_err), 32'd1);
        chk("seq_bad_key_out", 32'(out_key), 32'd3);
        tick("seq", 1'b1, 4'd3, 1'b1, 1'b0);
        tick("seq", 1'b1, 4'd4, 1'b1, 1'b0);
        chk("seq_err_sticky", 32'(seq_err), 32'd1);
        chk("seq_next_key", 32'(out_key), 32'd4);

        // count=1 with simultaneous capture and pop
        do_reset();
        tick("pp", 1'b1, 4'd0, 1'b0, 1'b0);
        tick("pp", 1'b0, 4'd0, 1'b0, 1'b0);
        chk("pp_count_before", 32'(count), 32'd1);
        tick("pp", 1'b1, 4'd1, 1'b1, 1'b0);
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_out_key", 32'(out_key), 32'd1);

        // Reset while acknowledging with two keys buffered
        do_reset();
        tick("mid", 1'b1, 4'd0, 1'b0, 1'b0);
        tick("mid", 1'b1, 4'd0, 1'b0, 1'b0);
        tick("mid", 1'b1, 4'd1, 1'b0, 1'b0);
        chk("mid_pre_ack", 32'(ack), 32'd1);
        chk("mid_pre_count", 32'(count), 32'd2);
        tick("mid_rst", 1'b1, 4'd1, 1'b0, 1'b1);
        chk("mid_ack", 32'(ack), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        tick("mid_restart", 1'b1, 4'd0, 1'b0, 1'b0);
        chk("mid_restart_err", 32'(seq_err), 32'd0);

        // Idle request line
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick("idle", 1'b0, key_t'($urandom_range(15, 0)), 1'b1, 1'b0);
            chk("idle_ack", 32'(ack), 32'd0);
            chk("idle_key", 32'(out_key), 32'd0);
        end

        // Randomized traffic: mostly in-order keys, occasional glitches and resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit   a;
            bit   r;
            bit   rdy;
            bit   rs;
            key_t k;
            a   = m_ack;
            r   = ($urandom_range(3, 0) != 0);
            rdy = ($urandom_range(2, 0) == 0);
            rs  = ($urandom_range(99, 0) == 0);
            k   = ($urandom_range(19, 0) == 0) ? key_t'($urandom_range(15, 0)) : prod_key;
            tick("rand", r, k, rdy, rs);
            if (rs) prod_key = 4'd0;
            else if (a) prod_key = prod_key + 4'd1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_responder

// File: doc/key_responder.md
# key_responder

Downstream consumer of the request/key producer stage. Accepts `req`/`req_key` transactions, returns a registered one-cycle `ack`, checks that keys arrive in strict modulo-16 increment order, and buffers accepted keys in a small FIFO drained through a valid/ready port. `ack` has no combinational path from `req` or `req_key`, so the producer's combinational `ack -> counter_next` path cannot form a loop through this block.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `KEY_W`, 4: key width; must match the producer's 4-bit key.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  1  producer request; may be held high continuously.
- `req_key`  in  KEY_W  key presented with `req`.
- `ack`  out  1  registered; high for exactly one cycle per accepted key.
- `out_valid`  out  1  FIFO non-empty.
- `out_key`  out  KEY_W  FIFO head key; 0 when empty.
- `out_ready`  in  1  consumer pop; a pop occurs when `out_valid && out_ready`.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `seq_err`  out  1  sticky; set on the first out-of-order key.

## Operation
- FSM states: IDLE, ACK. Reset state is IDLE.
- IDLE transitions:
  - If `req && count < DEPTH`: capture `req_key`, push it into the FIFO, and go to ACK.
  - Otherwise: stay in IDLE.
- ACK: `ack`=1 and nothing is captured. Always return to IDLE next cycle. The producer's key is stale during this cycle and is updated at the end of it.
- Full check uses the current `count` only. A same-cycle pop does not enable acceptance.
- Sequence check:
  - `exp_key` register resets to 0.
  - On every capture, compare `req_key` to `exp_key`. On mismatch, set `seq_err`, which stays set until `rst`.
  - Then set `exp_key = req_key + 1` (mod 2^KEY_W, wraps 15→0).
  - Mismatched keys are still enqueued.
- FIFO:
  - Simultaneous push and pop is allowed. `count` is unchanged and head/tail pointers advance independently.
  - Popping when empty is ignored.
- Reset values: `ack`=0, `out_valid`=0, `out_key`=0, `count`=0, `seq_err`=0. State is IDLE, `exp_key`=0, pointers are 0. FIFO contents are don't-care but `out_key` is gated to 0.
- Reset mid-handshake: if `rst` is asserted during ACK, `ack` is 0 the next cycle and any buffered keys are discarded.

## Timing
- Capture in cycle N, then `ack`=1 in cycle N+1. `out_valid` and `out_key` reflect the pushed key from cycle N+1.
- Maximum throughput is one key per 2 cycles. With `req` held high and the FIFO never full, `ack` toggles 0,1,0,1… starting from the first IDLE cycle after reset.
- A pop in cycle M updates `out_key`/`count` in cycle M+1.
- When full, the block stalls in IDLE with `ack`=0. Acceptance resumes in the first IDLE cycle after `count` drops below DEPTH.
- All outputs come directly from flops, or from a registered pointer-indexed read gated by the registered empty flag. There is no input→output combinational path.

## Structure
- Shared package `handshake_pkg` contains:
  - `KEY_W` localparam (4).
  - `resp_state_e` enum {IDLE, ACK}.
  - `key_t` typedef (`logic [KEY_W-1:0]`).
- Sub-module `sync_fifo` (params DEPTH, WIDTH):
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - Synchronous `rst` clears pointers.
- The top level holds the FSM, the `exp_key`/`seq_err` logic, and the `sync_fifo` instance.

## Test plan
- Reset then hold `req`=1 with `req_key` modelled as the producer (counter incrementing on `ack`), and `out_ready`=1. Expect `ack` at cycles 1,3,5…, `out_key` sequence 0,1,2,…,15,0, and `seq_err` stays 0 across the wrap.
- Same stimulus with `out_ready`=0. Expect exactly 4 acks with keys 0–3, then `count`=4 and `ack` held 0. Raise `out_ready` for one cycle: `count`=3, then the next ack captures key 4.
- Drive `req_key` sequence 0,1,3. Expect `seq_err` rises after the third capture and stays 1. Next expected key is 4, and key 3 is still delivered on `out_key`.
- `count`=1 with a simultaneous capture and pop. Expect `count` stays 1 and `out_key` advances to the new key.
- Assert `rst` in the cycle `ack`=1 with `count`=2. Expect the next cycle shows `ack`=0, `count`=0, `out_valid`=0, `seq_err`=0, and key 0 expected again.
- `req`=0 for 10 cycles after reset. Expect `ack`=0 throughout, `out_valid`=0, and `out_key`=0.
